// File: rtl/bus_outer_in_prefetch_adapter.sv
// Purpose : Prefetches outer input words into a DEPTH-entry FIFO and releases them to a
//           busSwitch input under a per-command word count (size 0 = automatic, the hub ends it).
// Latency : A pushed word is visible on h__in one cycle later at the earliest (registered FIFO, no bypass).
// Backpressure: o__in_canReceive = FIFO not full. A push is refused when the FIFO is full, even if a pop
//           happens in the same cycle. The hub stalls the head word via h__in_canReceive.
// Optional: `define BUS_OUTER_IN_FLUSH_EN adds a 'flush' input. The FIFO is cleared while IDLE.
// Ports   : clk, rst (async active-high); cmd/cmd_isReady/cmd_canReceive (command handshake);
//           o__in/o__in_isReady/o__in_canReceive (outer side); h__in/h__in_isReady/h__in_canReceive,
//           h__in_isLast_in, h__in_isLast_out (hub side); occupancy (words buffered).

// Purpose : Generic registered FIFO used by the adapter. Storage and pointers are reset to zero.
// Latency : Write at edge t; the word is readable from t+1. The head word is always driven on popDat.
// Backpressure: Caller gates pushVld with ~full and popVld with ~empty. Clear wins over push.
module bus_outer_in_prefetch_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       pushVld,
   input  logic [DATA_W-1:0]          pushDat,
   input  logic                       popVld,
   output logic [DATA_W-1:0]          popDat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;

   // DEPTH is a power of two, so natural pointer overflow gives the modulo-DEPTH wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         rdPtr <= wrPtr;
         count <= '0;
      end else begin
         if (pushVld) begin
            mem[wrPtr] <= pushDat;
            wrPtr      <= wrPtr + AW'(1);
         end
         if (popVld) rdPtr <= rdPtr + AW'(1);
         case ({pushVld, popVld})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign popDat = mem[rdPtr];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
endmodule

module bus_outer_in_prefetch_adapter #(
   parameter int DATA_W = 64,
   parameter int LEN_W  = 15,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef BUS_OUTER_IN_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic [LEN_W-1:0]           cmd,
   input  logic                       cmd_isReady,
   output logic                       cmd_canReceive,
   input  logic [DATA_W-1:0]          o__in,
   input  logic                       o__in_isReady,
   output logic                       o__in_canReceive,
   output logic [DATA_W-1:0]          h__in,
   output logic                       h__in_isReady,
   input  logic                       h__in_canReceive,
   output logic                       h__in_isLast_in,
   input  logic                       h__in_isLast_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   typedef enum logic [1:0] {IDLE, COUNTED, AUTO} stateT;

   stateT            state, nextState;
   logic [LEN_W-1:0] remaining, nextRemaining;
   logic             full, empty;
   logic             push, pop, clear;

   assign push = o__in_isReady & ~full;
   assign pop  = h__in_isReady & h__in_canReceive;

`ifdef BUS_OUTER_IN_FLUSH_EN
   // Only honoured between commands. No pop can occur while IDLE, so clearing is safe.
   assign clear = flush & (state == IDLE);
`else
   assign clear = 1'b0;
`endif

   bus_outer_in_prefetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .pushVld (push),
      .pushDat (o__in),
      .popVld  (pop),
      .popDat  (h__in),
      .full    (full),
      .empty   (empty),
      .count   (occupancy)
   );

   assign o__in_canReceive = ~full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         state     <= nextState;
         remaining <= nextRemaining;
      end
   end

   always_comb begin
      nextState       = state;
      nextRemaining   = remaining;
      cmd_canReceive  = 1'b0;
      h__in_isReady   = 1'b0;
      h__in_isLast_in = 1'b0;
      case (state)
         IDLE: begin
            cmd_canReceive = 1'b1;
            if (cmd_isReady) begin
               if (cmd != '0) begin
                  nextState     = COUNTED;
                  nextRemaining = cmd;
               end else begin
                  nextState = AUTO;
               end
            end
         end
         COUNTED: begin
            h__in_isReady   = ~empty;
            h__in_isLast_in = (remaining == LEN_W'(1)) & ~empty;
            if (pop) begin
               nextRemaining = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) nextState = IDLE;
            end
         end
         AUTO: begin
            // The hub's end marker only counts when it coincides with a pop.
            // Unpopped words stay buffered for the next command.
            h__in_isReady = ~empty;
            if (pop && h__in_isLast_out) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bus_outer_in_prefetch_adapter.sv
module tb_bus_outer_in_prefetch_adapter;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 15;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic [LEN_W-1:0]  cmd = '0;
   logic              cmd_isReady = 1'b0;
   logic              cmd_canReceive;
   logic [DATA_W-1:0] o__in = '0;
   logic              o__in_isReady = 1'b0;
   logic              o__in_canReceive;
   logic [DATA_W-1:0] h__in;
   logic              h__in_isReady;
   logic              h__in_canReceive = 1'b0;
   logic              h__in_isLast_in;
   logic              h__in_isLast_out = 1'b0;
   logic [CW-1:0]     occupancy;

   bus_outer_in_prefetch_adapter #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
`ifdef BUS_OUTER_IN_FLUSH_EN
      .flush            (flush),
`endif
      .cmd              (cmd),
      .cmd_isReady      (cmd_isReady),
      .cmd_canReceive   (cmd_canReceive),
      .o__in            (o__in),
      .o__in_isReady    (o__in_isReady),
      .o__in_canReceive (o__in_canReceive),
      .h__in            (h__in),
      .h__in_isReady    (h__in_isReady),
      .h__in_canReceive (h__in_canReceive),
      .h__in_isLast_in  (h__in_isLast_in),
      .h__in_isLast_out (h__in_isLast_out),
      .occupancy        (occupancy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: queue of buffered words, mode 0=idle 1=counted 2=auto, words left in command.
   logic [63:0] mq[$];
   int          mMode = 0;
   int          mRem  = 0;

   task automatic checkOutputs();
      bit hv;
      hv = (mMode != 0) && (mq.size() > 0);
      checkVal("cmdRdy", cmd_canReceive, mMode == 0);
      checkVal("inRdy", o__in_canReceive, mq.size() < DEPTH);
      checkVal("hVld", h__in_isReady, hv);
      checkVal("isLast", h__in_isLast_in, (mMode == 1) && (mRem == 1) && (mq.size() > 0));
      checkVal("occ", occupancy, mq.size());
      if (hv) checkVal("hDat", h__in, mq[0]);
   endtask

   // Called at a falling edge: check, drive one cycle of inputs, advance the model, wait one cycle.
   task automatic step(input bit iv, input logic [63:0] d, input bit cv, input logic [LEN_W-1:0] cs,
                       input bit hr, input bit lo, input bit fl);
      bit hv, pop, push, doFlush;
      checkOutputs();
      o__in_isReady    = iv;
      o__in            = d;
      cmd_isReady      = cv;
      cmd              = cs;
      h__in_canReceive = hr;
      h__in_isLast_out = lo;
      flush            = fl;
      hv   = (mMode != 0) && (mq.size() > 0);
      pop  = hv && hr;
      push = iv && (mq.size() < DEPTH);
`ifdef BUS_OUTER_IN_FLUSH_EN
      doFlush = fl && (mMode == 0);
`else
      doFlush = 1'b0;
`endif
      if (doFlush) begin
         mq.delete();
         push = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
      case (mMode)
         0: if (cv) begin
               if (cs != 0) begin mMode = 1; mRem = int'(cs); end
               else mMode = 2;
            end
         1: if (pop) begin
               mRem--;
               if (mRem == 0) mMode = 0;
            end
         default: if (pop && lo) mMode = 0;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asserts reset at a falling edge and checks the outputs follow it without waiting for a clock.
   task automatic doReset();
      rst = 1'b1;
      o__in_isReady = 1'b0; cmd_isReady = 1'b0; h__in_canReceive = 1'b0;
      h__in_isLast_out = 1'b0; flush = 1'b0; o__in = '0; cmd = '0;
      #1;
      checkVal("rstCmdRdy", cmd_canReceive, 1);
      checkVal("rstInRdy", o__in_canReceive, 1);
      checkVal("rstHVld", h__in_isReady, 0);
      checkVal("rstLast", h__in_isLast_in, 0);
      checkVal("rstHDat", h__in, 0);
      checkVal("rstOcc", occupancy, 0);
      mq.delete(); mMode = 0; mRem = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   localparam logic [63:0] WA = 64'hA0A0_0000_0000_000A;
   localparam logic [63:0] WB = 64'hB0B0_0000_0000_000B;
   localparam logic [63:0] WC = 64'hC0C0_0000_0000_000C;
   localparam logic [63:0] WD = 64'hD000_0000_0000_0000;

   initial begin
      int pops, lasts, gaps;
      logic [63:0] k;
      @(negedge clk);
      doReset();

      // Three words buffered with no command.
      step(1, WA, 0, 0, 0, 0, 0);
      step(1, WB, 0, 0, 0, 0, 0);
      step(1, WC, 0, 0, 0, 0, 0);
      checkVal("s1Occ", occupancy, 3);
      checkVal("s1HVld", h__in_isReady, 0);
      checkVal("s1CmdRdy", cmd_canReceive, 1);

      // Counted command of 2 leaves C buffered.
      step(0, 0, 1, 2, 1, 0, 0);
      checkVal("s2A", h__in, WA);
      checkVal("s2LastA", h__in_isLast_in, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      checkVal("s2B", h__in, WB);
      checkVal("s2LastB", h__in_isLast_in, 1);
      step(0, 0, 0, 0, 1, 0, 0);
      checkVal("s2Idle", cmd_canReceive, 1);
      checkVal("s2OccC", occupancy, 1);

      // Automatic command ended by the hub on the second pop; remaining words feed the next command.
      doReset();
      for (int i = 0; i < 4; i++) step(1, WD + 64'(i), 0, 0, 0, 0, 0);
      checkVal("s3Full", o__in_canReceive, 0);
      step(0, 0, 1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      checkVal("s3Idle", cmd_canReceive, 1);
      checkVal("s3Occ", occupancy, 2);
      step(0, 0, 1, 2, 1, 0, 0);
      checkVal("s3D2", h__in, WD + 64'd2);
      step(0, 0, 0, 0, 1, 0, 0);
      checkVal("s3D3", h__in, WD + 64'd3);
      checkVal("s3LastD3", h__in_isLast_in, 1);
      step(0, 0, 0, 0, 1, 0, 0);
      checkVal("s3Empty", occupancy, 0);

      // Full FIFO: push refused during a pop, then streaming through pointer wrap.
      doReset();
      for (int i = 0; i < 4; i++) step(1, 64'h100 + 64'(i), 0, 0, 0, 0, 0);
      step(0, 0, 1, LEN_W'(3 * DEPTH), 0, 0, 0);
      checkVal("s4InRdy", o__in_canReceive, 0);
      step(1, 64'hDEAD, 0, 0, 1, 0, 0);
      checkVal("s4Occ", occupancy, DEPTH - 1);
      k = 64'h104;
      for (int i = 0; i < 3 * DEPTH + 4; i++) begin
         step(1, k, 0, 0, 1, 0, 0);
         k++;
      end
      checkVal("s4Done", cmd_canReceive, 1);

      // Counted command of 5 fed one word every 3 cycles.
      doReset();
      pops = 0; lasts = 0; gaps = 0;
      step(0, 0, 1, 5, 1, 0, 0);
      for (int i = 0; i < 40; i++) begin
         if (cmd_canReceive) break;
         if (h__in_isReady) pops++; else gaps++;
         if (h__in_isLast_in) begin
            lasts++;
            checkVal("s5LastOn5th", pops, 5);
         end
         step(i % 3 == 0, 64'h500 + 64'(i), 0, 0, 1, 0, 0);
      end
      checkVal("s5Pops", pops, 5);
      checkVal("s5Lasts", lasts, 1);
      checkVal("s5Gaps", gaps > 0, 1);
      checkVal("s5Idle", cmd_canReceive, 1);
      step(1, 64'h600, 1, 3, 0, 0, 0);
      step(1, 64'h601, 0, 0, 0, 0, 0);
      checkVal("s5PreRstVld", h__in_isReady, 1);
      doReset();

`ifdef BUS_OUTER_IN_FLUSH_EN
      for (int i = 0; i < 3; i++) step(1, 64'h700 + 64'(i), 0, 0, 0, 0, 0);
      step(1, 64'h7FF, 0, 0, 0, 0, 1);
      checkVal("fOccIdle", occupancy, 0);
      for (int i = 0; i < 3; i++) step(1, 64'h710 + 64'(i), 0, 0, 0, 0, 0);
      step(0, 0, 1, 5, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      checkVal("fOccCounted", occupancy, 3);
      doReset();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, {$urandom, $urandom},
              $urandom_range(0, 1) == 1, LEN_W'($urandom_range(0, 6)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0);
      end
      checkOutputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_outer_in_prefetch_adapter.md
Name: bus_outer_in_prefetch_adapter

Overview:
- Parametrised, buffered successor to the outer-input adapter.
- Prefetches outer input words into a DEPTH-entry FIFO, independent of commands.
- Releases words to the hub under a per-command word count; size 0 means automatic mode, where the hub ends the transfer.
- Sits between an outer input port and one `busSwitch` input. Words left over from automatic mode stay buffered for the next command.

Parameters:
- DATA_W, 64, data word width.
- LEN_W, 15, command size width; max words per command is 2^LEN_W-1.
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- cmd  input  LEN_W  word count; 0 = automatic
- cmd_isReady  input  1  command valid
- cmd_canReceive  output  1  command accepted when high with cmd_isReady
- o__in  input  DATA_W  outer data
- o__in_isReady  input  1  outer word valid
- o__in_canReceive  output  1  FIFO not full
- h__in  output  DATA_W  FIFO head word to hub
- h__in_isReady  output  1  hub word valid
- h__in_canReceive  input  1  hub accepts
- h__in_isLast_in  output  1  current word is last of counted command
- h__in_isLast_out  input  1  hub-side end marker (automatic mode)
- occupancy  output  $clog2(DEPTH+1)  words buffered

Behaviour:
- Decided: one clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE, FIFO empty, remaining=0, storage=0. Outputs: cmd_canReceive=1, o__in_canReceive=1, h__in_isReady=0, h__in_isLast_in=0, h__in=0, occupancy=0.
- Push: o__in_isReady & o__in_canReceive, in any state. o__in_canReceive = ~full; no push when full, even if a pop happens in the same cycle.
- Pop: h__in_isReady & h__in_canReceive.
- FIFO is registered with no bypass: a word pushed at cycle t is visible on h__in at t+1 at the earliest.
- Simultaneous push and pop (not full): occupancy unchanged.
- Pointers wrap modulo DEPTH.
- States: IDLE, COUNTED, AUTO. cmd_canReceive = (state==IDLE).
- IDLE, command accepted: size≠0 → COUNTED with remaining=size; size=0 → AUTO. The new state is active from the next cycle.
- h__in_isReady = (state≠IDLE) & ~empty.
- COUNTED:
  - h__in_isLast_in = (remaining==1) & ~empty.
  - Each pop decrements remaining.
  - A pop with remaining==1 → IDLE next cycle.
- AUTO:
  - h__in_isLast_in=0.
  - A pop with h__in_isLast_out=1 → IDLE next cycle.
  - h__in_isLast_out without a pop is ignored.
  - Remaining FIFO words are retained.
- Back-to-back commands: the earliest acceptance of the next command is the cycle after the final pop. There are no bubbles from the FIFO side.
- cmd_isReady in a non-IDLE state has no effect.
- Reset mid-command: immediate return to reset values; buffered data is lost.
- Empty FIFO during a command: h__in_isReady=0 and the state is held.

Optional Feature:
- Macro: BUS_OUTER_IN_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 while IDLE empties the FIFO at the next edge (occupancy→0); a push in that same cycle is discarded.
  - flush is ignored outside IDLE.
- When undefined: no flush port; the FIFO is emptied only by pops or rst.

Test Plan:
- Reset, then push 3 words (A,B,C) with no command → occupancy=3, h__in_isReady=0, cmd_canReceive=1.
- Command size=2 with A,B,C buffered:
  - A popped at t+1, with isLast_in=0.
  - B popped at t+2, with isLast_in=1.
  - State IDLE at t+3; occupancy=1 (C retained).
- Command size=0 with DEPTH=4 full (D0..D3); hub asserts h__in_isLast_out on the 2nd pop → IDLE, D2 and D3 delivered first by the next command size=2.
- Full FIFO with simultaneous pop and o__in_isReady=1 → push refused (o__in_canReceive=0), occupancy DEPTH-1 next cycle; pointer wrap verified over 3·DEPTH words in order.
- Counted command size=5 with outer feeding 1 word every 3 cycles → h__in_isReady gaps, exactly 5 pops, isLast_in only on the 5th; rst asserted mid-transfer → all outputs at reset values in the same cycle.
- With BUS_OUTER_IN_FLUSH_EN: 3 words buffered, flush=1 in IDLE → occupancy=0 next cycle; flush=1 during COUNTED → no effect.
